// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU command sequencer and its unit decoder.
package alu_ctrl_pkg;

  localparam int FUN_WIDTH = 4;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

endpackage

// File: rtl/alu_unit_decoder.sv
// Maps a unit select plus an active flag onto the four one-hot ALU unit enables.
module alu_unit_decoder
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] unit_sel,
  input  logic       active,
  output logic       arith_en,
  output logic       logic_en,
  output logic       cmp_en,
  output logic       shift_en
);

  // One-hot decode, all enables low when inactive
  always_comb begin
    arith_en = 1'b0;
    logic_en = 1'b0;
    cmp_en   = 1'b0;
    shift_en = 1'b0;
    if (active) begin
      case (unit_sel)
        UNIT_ARITH: arith_en = 1'b1;
        UNIT_LOGIC: logic_en = 1'b1;
        UNIT_CMP:   cmp_en   = 1'b1;
        UNIT_SHIFT: shift_en = 1'b1;
        default:    arith_en = 1'b0;
      endcase
    end else begin
      arith_en = 1'b0;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-level ALU controller: accepts one op, drives the selected unit until its
// registered result is valid, then returns that result over a valid/ready response port.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int CMP_WIDTH  = 4,
  parameter int UNIT_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic [FUN_WIDTH-1:0]  cmd_fun,
  output logic [DATA_WIDTH-1:0] unit_a,
  output logic [DATA_WIDTH-1:0] unit_b,
  output logic [1:0]            unit_fun,
  output logic                  arith_en,
  output logic                  logic_en,
  output logic                  cmp_en,
  output logic                  shift_en,
  input  logic [OUT_WIDTH-1:0]  arith_res,
  input  logic [OUT_WIDTH-1:0]  logic_res,
  input  logic [OUT_WIDTH-1:0]  shift_res,
  input  logic [CMP_WIDTH-1:0]  cmp_res,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [OUT_WIDTH-1:0]  rsp_data,
  output logic [1:0]            rsp_unit,
  output logic                  busy,
  output logic [15:0]           op_count
);

  state_e                state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [FUN_WIDTH-1:0]  fun_q, fun_d;
  logic [OUT_WIDTH-1:0]  rsp_data_q, rsp_data_d, unit_out;
  logic [1:0]            rsp_unit_q, rsp_unit_d;
  logic [15:0]           op_count_q, op_count_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  busy_q, busy_d;
  logic                  arith_en_q, logic_en_q, cmp_en_q, shift_en_q;
  logic                  arith_en_d, logic_en_d, cmp_en_d, shift_en_d;
  logic                  dec_active;

  // Result mux over the currently latched unit select
  always_comb begin
    unit_out = '0;
    case (fun_q[3:2])
      UNIT_ARITH: unit_out = arith_res;
      UNIT_LOGIC: unit_out = logic_res;
      UNIT_CMP:   unit_out = OUT_WIDTH'(cmp_res);
      UNIT_SHIFT: unit_out = shift_res;
      default:    unit_out = '0;
    endcase
  end

  // Next-state logic and registered-output precompute
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    fun_d      = fun_q;
    rsp_data_d = rsp_data_q;
    rsp_unit_d = rsp_unit_q;
    op_count_d = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          fun_d   = cmd_fun;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        wait_cnt_d = 4'(UNIT_LAT - 1);
        state_d    = (UNIT_LAT == 1) ? ST_CAPTURE : ST_WAIT;
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_CAPTURE: begin
        rsp_data_d = unit_out;
        rsp_unit_d = fun_q[3:2];
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered, so they are derived from the upcoming state
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    busy_d      = (state_d != ST_IDLE);
    dec_active  = (state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_CAPTURE);
  end

  alu_unit_decoder u_dec (
    .unit_sel (fun_d[3:2]),
    .active   (dec_active),
    .arith_en (arith_en_d),
    .logic_en (logic_en_d),
    .cmp_en   (cmp_en_d),
    .shift_en (shift_en_d)
  );

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 4'd0;
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      rsp_data_q  <= '0;
      rsp_unit_q  <= 2'b00;
      op_count_q  <= 16'd0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      arith_en_q  <= 1'b0;
      logic_en_q  <= 1'b0;
      cmp_en_q    <= 1'b0;
      shift_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fun_q       <= fun_d;
      rsp_data_q  <= rsp_data_d;
      rsp_unit_q  <= rsp_unit_d;
      op_count_q  <= op_count_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      arith_en_q  <= arith_en_d;
      logic_en_q  <= logic_en_d;
      cmp_en_q    <= cmp_en_d;
      shift_en_q  <= shift_en_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign unit_a    = a_q;
  assign unit_b    = b_q;
  assign unit_fun  = fun_q[1:0];
  assign arith_en  = arith_en_q;
  assign logic_en  = logic_en_q;
  assign cmp_en    = cmp_en_q;
  assign shift_en  = shift_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_unit  = rsp_unit_q;
  assign busy      = busy_q;
  assign op_count  = op_count_q;

endmodule
